// File: rtl/bytewrite_ram_master_if.sv
// Request, response and RAM-side signal bundle for bytewrite_ram_master.
// The master modport is the controller's view; slave is the requester/RAM environment.
interface bytewrite_ram_master_if #(
   parameter int AW = 10,
   parameter int NB = 4
);
   logic              req_valid;
   logic              req_ready;
   logic [NB-1:0]     req_we;
   logic [AW-1:0]     req_addr;
   logic [NB*8-1:0]   req_wdata;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [NB*8-1:0]   rsp_rdata;
   logic [NB-1:0]     ram_we;
   logic [AW-1:0]     ram_addr;
   logic [NB*8-1:0]   ram_din;
   logic [NB*8-1:0]   ram_dout;

   modport master (
      input  req_valid, req_we, req_addr, req_wdata, rsp_ready, ram_dout,
      output req_ready, rsp_valid, rsp_rdata, ram_we, ram_addr, ram_din
   );

   modport slave (
      output req_valid, req_we, req_addr, req_wdata, rsp_ready, ram_dout,
      input  req_ready, rsp_valid, rsp_rdata, ram_we, ram_addr, ram_din
   );
endinterface

// File: rtl/bytewrite_ram_master.sv
// Requester-side controller for a 2-cycle-latency byte-write RAM: issues one op per
// cycle and returns read data in order through a credit-guarded response FIFO.
module bytewrite_ram_master_chk #(
   parameter int RSP_DEPTH = 4,
   parameter int CW        = 3
) (
   input logic          clk,
   input logic          rst,
   input logic          push,
   input logic          pop,
   input logic [CW-1:0] count
);
   a_no_overflow: assert property (@(posedge clk) disable iff (rst)
      !(push && (count == CW'(RSP_DEPTH))));
   a_no_underflow: assert property (@(posedge clk) disable iff (rst)
      !(pop && (count == {CW{1'b0}})));
endmodule

module bytewrite_ram_master #(
   parameter int AW        = 10,
   parameter int NB        = 4,
   parameter int RSP_DEPTH = 4
) (
   input logic                   clk,
   input logic                   rst,
   bytewrite_ram_master_if.master bus
);
   localparam int DW = NB * 8;
   localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
   localparam int CW = PW + 1;

   logic          p1_q, p2_q;
   logic [CW-1:0] count_q, count_d;
   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [DW-1:0] fifo_q [RSP_DEPTH];

   logic          req_ready_s, fire_s, is_read_s, push_s, pop_s, rsp_valid_s;
   logic [CW:0]   outstanding_s;
   logic [AW-1:0] addr_s;

   // Credits count reads in the RAM pipe plus queued data, so a push always has a slot.
   assign outstanding_s = {1'b0, count_q} + (CW+1)'(p1_q) + (CW+1)'(p2_q);
   assign req_ready_s   = (outstanding_s < (CW+1)'(RSP_DEPTH)) & ~rst;
   assign fire_s        = bus.req_valid & req_ready_s;
   assign is_read_s     = (bus.req_we == {NB{1'b0}});
   assign push_s        = p2_q;
   assign rsp_valid_s   = (count_q != {CW{1'b0}});
   assign pop_s         = rsp_valid_s & bus.rsp_ready;
   assign addr_s        = bus.req_addr;

   assign bus.req_ready = req_ready_s;
   assign bus.rsp_valid = rsp_valid_s;
   assign bus.rsp_rdata = fifo_q[rd_ptr_q];
   assign bus.ram_we    = fire_s ? bus.req_we : {NB{1'b0}};
   assign bus.ram_addr  = addr_s;
   assign bus.ram_din   = bus.req_wdata;

   always_comb begin
      count_d = count_q;
      case ({push_s, pop_s})
         2'b10:   count_d = count_q + CW'(1'b1);
         2'b01:   count_d = count_q - CW'(1'b1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         p1_q     <= 1'b0;
         p2_q     <= 1'b0;
         count_q  <= {CW{1'b0}};
         wr_ptr_q <= {PW{1'b0}};
         rd_ptr_q <= {PW{1'b0}};
      end else begin
         p1_q    <= fire_s & is_read_s;
         p2_q    <= p1_q;
         count_q <= count_d;
         if (push_s) begin
            fifo_q[wr_ptr_q] <= bus.ram_dout;
            wr_ptr_q         <= wr_ptr_q + PW'(1'b1);
         end else begin
            wr_ptr_q <= wr_ptr_q;
         end
         if (pop_s) begin
            rd_ptr_q <= rd_ptr_q + PW'(1'b1);
         end else begin
            rd_ptr_q <= rd_ptr_q;
         end
      end
   end

   bytewrite_ram_master_chk #(.RSP_DEPTH(RSP_DEPTH), .CW(CW)) u_chk (
      .clk   (clk),
      .rst   (rst),
      .push  (push_s),
      .pop   (pop_s),
      .count (count_q)
   );
endmodule

// File: tb/tb_bytewrite_ram_master.sv
// Self-checking bench: RAM model, scoreboard of expected read data, table plus corner sequences.
module tb_bytewrite_ram_master;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   bytewrite_ram_master_if #(.AW(10), .NB(4)) bus ();

   bytewrite_ram_master #(.AW(10), .NB(4), .RSP_DEPTH(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Read-first RAM: inputs registered, then dout registered.
   logic [31:0] mem [1024];
   logic [3:0]  we_r;
   logic [9:0]  a_r;
   logic [31:0] d_r;
   always @(posedge clk) begin
      we_r <= bus.ram_we;
      a_r  <= bus.ram_addr;
      d_r  <= bus.ram_din;
      bus.ram_dout <= mem[a_r];
      for (int i = 0; i < 4; i++)
         if (we_r[i]) mem[a_r][i*8 +: 8] <= d_r[i*8 +: 8];
   end

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   int pops     = 0;
   int last_pop_cyc = 0;
   logic [31:0] exp_q [$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   always @(negedge clk) begin
      if (!rst && bus.rsp_valid && bus.rsp_ready) begin
         pops++;
         last_pop_cyc = cyc;
         if (exp_q.size() == 0) check("rsp_unexpected", 32'd1, 32'd0);
         else check("rsp_data", bus.rsp_rdata, exp_q.pop_front());
      end
   end

   typedef struct {
      logic [3:0]  we;
      logic [9:0]  addr;
      logic [31:0] wdata;
      logic [31:0] exp;
   } vec_t;
   vec_t vecs [6];

   // Presents one request (left asserted on return) and waits, bounded, for acceptance.
   task automatic send(input logic [3:0] we, input logic [9:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp, input bit track, output int waited, output int fcyc);
      bit fired = 1'b0;
      waited = 0;
      fcyc   = 0;
      bus.req_valid = 1'b1;
      bus.req_we    = we;
      bus.req_addr  = addr;
      bus.req_wdata = wdata;
      while (!fired && waited < 50) begin
         @(negedge clk);
         if (bus.req_ready) begin
            fired = 1'b1;
            fcyc  = cyc;
            if (we == 4'h0 && track) exp_q.push_back(exp);
         end else begin
            waited++;
         end
         @(posedge clk);
         #1;
      end
      if (!fired) check("send_timeout", 32'd0, 32'd1);
   endtask

   task automatic idle();
      bus.req_valid = 1'b0;
      bus.req_we    = 4'h0;
   endtask

   task automatic drain();
      int b = 0;
      while (exp_q.size() != 0 && b < 100) begin
         @(posedge clk);
         b++;
      end
      #1;
      check("drain", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic read_latency(input logic [9:0] addr, input logic [31:0] exp, input string name);
      int w, f, lat;
      bus.rsp_ready = 1'b1;
      send(4'h0, addr, 32'h0, exp, 1'b1, w, f);
      idle();
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!bus.rsp_valid && lat < 20);
      check(name, 32'(lat), 32'd3);
      @(posedge clk);
      #1;
      drain();
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int w, f, first, waits, p0, accepted, vcount;
      bit fired;
      vecs[0] = '{4'hF, 10'd5, 32'hDEADBEEF, 32'h0};
      vecs[1] = '{4'h0, 10'd5, 32'h0,        32'hDEADBEEF};
      vecs[2] = '{4'h2, 10'd5, 32'h0000AA00, 32'h0};
      vecs[3] = '{4'h0, 10'd5, 32'h0,        32'hDEADAAEF};
      vecs[4] = '{4'hF, 10'd7, 32'h11223344, 32'h0};
      vecs[5] = '{4'h0, 10'd7, 32'h0,        32'h11223344};

      // Reset state, with a write request pending that must not reach the RAM.
      rst = 1'b1;
      bus.rsp_ready = 1'b0;
      bus.req_valid = 1'b1;
      bus.req_we    = 4'hF;
      bus.req_addr  = 10'd0;
      bus.req_wdata = 32'h0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_req_ready", 32'(bus.req_ready), 32'd0);
      check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("rst_ram_we", 32'(bus.ram_we), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      idle();
      @(negedge clk);
      check("post_rst_ready", 32'(bus.req_ready), 32'd1);
      check("post_rst_valid", 32'(bus.rsp_valid), 32'd0);
      @(posedge clk);
      #1;

      // Table: full write, read, partial write, read, write-then-read hazard.
      bus.rsp_ready = 1'b1;
      for (int i = 0; i < 6; i++)
         send(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp, 1'b1, w, f);
      idle();
      drain();

      send(4'hF, 10'd5, 32'hDEADBEEF, 32'h0, 1'b1, w, f);
      idle();
      repeat (3) @(posedge clk);
      #1;
      read_latency(10'd5, 32'hDEADBEEF, "latency_first");

      for (int a = 0; a < 16; a++)
         send(4'hF, 10'(a), 32'(a), 32'h0, 1'b1, w, f);
      idle();
      repeat (4) @(posedge clk);
      #1;

      // Back-to-back reads with the consumer always ready.
      waits = 0;
      first = 0;
      p0 = pops;
      for (int a = 0; a < 16; a++) begin
         send(4'h0, 10'(a), 32'h0, 32'(a), 1'b1, w, f);
         waits += w;
         if (a == 0) first = f;
      end
      idle();
      drain();
      check("b2b_ready_held", 32'(waits), 32'd0);
      check("b2b_span", 32'(last_pop_cyc - first), 32'd18);
      check("b2b_count", 32'(pops - p0), 32'd16);

      // Back-pressure: credits stop acceptance at RSP_DEPTH, then release.
      p0 = pops;
      bus.rsp_ready = 1'b0;
      accepted = 0;
      bus.req_valid = 1'b1;
      bus.req_we    = 4'h0;
      bus.req_addr  = 10'd0;
      repeat (12) begin
         @(negedge clk);
         fired = bus.req_ready;
         if (fired) exp_q.push_back(32'(accepted));
         @(posedge clk);
         #1;
         if (fired) accepted++;
         bus.req_addr = 10'(accepted);
      end
      check("bp_accepted", 32'(accepted), 32'd4);
      check("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      bus.rsp_ready = 1'b1;
      for (int a = accepted; a < 16; a++)
         send(4'h0, 10'(a), 32'h0, 32'(a), 1'b1, w, f);
      idle();
      drain();
      check("bp_count", 32'(pops - p0), 32'd16);

      // Reset while two reads are in flight: their data must vanish.
      p0 = pops;
      send(4'h0, 10'd3, 32'h0, 32'h3, 1'b0, w, f);
      send(4'h0, 10'd4, 32'h0, 32'h4, 1'b0, w, f);
      idle();
      rst = 1'b1;
      @(negedge clk);
      check("midrst_req_ready", 32'(bus.req_ready), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      vcount = 0;
      repeat (8) begin
         @(negedge clk);
         if (bus.rsp_valid) vcount++;
      end
      check("midrst_no_rsp", 32'(vcount), 32'd0);
      check("midrst_no_pop", 32'(pops - p0), 32'd0);
      @(posedge clk);
      #1;
      read_latency(10'd9, 32'd9, "latency_after_rst");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/bytewrite_ram_master.md
Name: bytewrite_ram_master

Overview:
- Requester-side controller that drives a single-port, byte-write-enabled, read-first RAM.
- The RAM registers its inputs, then registers dout, so read data arrives 2 cycles after the address is presented.
- Accepts read and byte-masked write requests on a valid/ready channel and issues one RAM op per cycle.
- Tracks read latency and returns read data in order on a valid/ready response channel, with a credit-guarded response FIFO so back-pressure never loses data.

Parameters:
- AW, 10, RAM address width.
- NB, 4, bytes per word; data width = NB*8.
- RSP_DEPTH, 4, response FIFO entries; power of 2, minimum 2; at least 4 is required for 1 read/cycle throughput.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid & req_ready.
- req_we  in  NB  byte write enables; all-zero means read.
- req_addr  in  AW  word address.
- req_wdata  in  NB*8  write data; byte i = bits [i*8 +: 8].
- rsp_valid  out  1  read data available.
- rsp_ready  in  1  consumer takes read data.
- rsp_rdata  out  NB*8  read data, in request order.
- ram_we  out  NB  to RAM write enables.
- ram_addr  out  AW  to RAM address.
- ram_din  out  NB*8  to RAM write data.
- ram_dout  in  NB*8  from RAM read data.

Behaviour:
- fire = req_valid & req_ready. Reads do not wait on writes, and writes do not wait on reads.
- RAM drive (combinational):
  - ram_we = fire ? req_we : 0.
  - ram_addr = req_addr; ram_din = req_wdata.
  - No RAM write can occur unless fire is true.
- Read tracking:
  - Two-stage shift register: p1 <= fire & (req_we==0); p2 <= p1.
  - When p2 = 1, ram_dout is valid in that cycle and is pushed into the FIFO at the next edge.
  - Accept-to-rsp_valid latency = 3 cycles with the FIFO empty.
- Writes generate no response. Mixed ops must never reorder read responses.
- Credits:
  - outstanding = p1 + p2 + fifo_count.
  - req_ready = (outstanding < RSP_DEPTH) & ~rst.
  - req_ready is a function of registers only: no combinational path from req_valid or rsp_ready.
  - A pop in the current cycle does not free a credit until the next cycle.
  - The FIFO therefore can never overflow; overflow is an assertion failure.
- FIFO:
  - rsp_valid = (fifo_count != 0); rsp_rdata = head entry.
  - Head entry holds stable while rsp_valid & ~rsp_ready.
  - Pop on rsp_valid & rsp_ready.
  - Simultaneous push and pop: count unchanged, pointers both advance modulo RSP_DEPTH, wrap-around is seamless.
  - Pop when empty is impossible.
- Hazards:
  - Write at cycle t, read of same address at t+1: the response returns the new data, because the RAM updates mem before the read's dout stage.
  - Only 1 op per cycle exists, so no same-cycle read/write conflict.
  - Partial write: only bytes with req_we[i]=1 change.
- Reset, whenever asserted (including mid-operation):
  - Next cycle: p1 = p2 = 0, fifo_count = 0, pointers = 0.
  - rsp_valid = 0, req_ready = 0 while rst is high, ram_we = 0.
  - In-flight reads are discarded; their late ram_dout is never pushed.
  - RAM contents are not cleared.
- rsp_rdata is don't-care when rsp_valid = 0.

Test Plan:
- Write 0xDEADBEEF to addr 5 with we=4'hF, then read addr 5 with rsp_ready=1 -> rsp_valid exactly 3 cycles after read fire, rsp_rdata=0xDEADBEEF.
- Write 0xDEADBEEF to addr 5, then we=4'b0010 with wdata 0x0000AA00 to addr 5, then read addr 5 -> 0xDEADAAEF.
- Write 0x11223344 to addr 7 at cycle t, read addr 7 at t+1 -> rsp_rdata=0x11223344 (no stale data).
- 16 back-to-back reads of addrs 0..15 (preloaded data = addr) with rsp_ready=1 -> req_ready held 1 throughout, responses 0..15 in order on consecutive cycles.
- Same 16 reads with rsp_ready=0 -> req_ready drops after exactly RSP_DEPTH=4 accepted; then release rsp_ready -> all 16 responses in order, none lost or duplicated, FIFO pointers wrap.
- Two reads accepted, rst asserted 1 cycle later for 1 cycle -> rsp_valid never asserts, req_ready=0 during rst; the next read afterwards returns correct data with 3-cycle latency.
